// File: rtl/pwq_activation.sv
// Piecewise-quadratic tanh/sigmoid unit: one sample per cycle, result 4 edges after accept.
// Global stall: the whole pipe, bubbles included, freezes while the output is held back.
module pwq_activation #(
  parameter int QN    = 6,
  parameter int QM    = 11,
  parameter int TAG_W = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [QN+QM:0]   in_data,
  input  logic             in_mode,
  input  logic [TAG_W-1:0] in_tag,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [QN+QM:0]   out_data,
  output logic [TAG_W-1:0] out_tag
);
  localparam int BW = QN + QM + 1;
  localparam int PW = 2 * BW + 1;
  localparam logic signed [BW:0] ONE   = (BW+1)'(1 << QM);
  localparam logic signed [BW:0] THREE = (BW+1)'(3 << QM);

  // Table coefficients are stored at QM = 11 and scaled up for finer formats.
  function automatic logic signed [BW:0] coef(input int c);
    return (BW+1)'(c) <<< (QM - 11);
  endfunction

  logic                    w_en;

  logic                    r0_vld, r0_mode;
  logic signed [BW-1:0]    r0_x;
  logic [TAG_W-1:0]        r0_tag;

  logic                    r1_vld, r1_mode;
  logic signed [BW-1:0]    r1_x;
  logic signed [BW:0]      r1_p2, r1_p1, r1_p0;
  logic [TAG_W-1:0]        r1_tag;

  logic                    r2_vld, r2_mode;
  logic signed [BW-1:0]    r2_x;
  logic signed [BW:0]      r2_m1, r2_p0;
  logic [TAG_W-1:0]        r2_tag;

  logic                    r3_vld, r3_mode;
  logic signed [BW:0]      r3_m2;
  logic [TAG_W-1:0]        r3_tag;

  logic                    r4_vld;
  logic [BW-1:0]           r4_dat;
  logic [TAG_W-1:0]        r4_tag;

  logic signed [BW-1:0]    w_xp;
  logic signed [BW:0]      w_xe;
  logic signed [BW:0]      w_p2, w_p1, w_p0;
  logic signed [PW-1:0]    w_prod1, w_prod2;
  logic signed [BW:0]      w_m1, w_m2;
  logic signed [BW:0]      w_t, w_sig;
  logic [BW-1:0]           w_res;

  assign w_en      = !(r4_vld && !out_ready);
  assign in_ready  = w_en;
  assign out_valid = r4_vld;
  assign out_data  = r4_dat;
  assign out_tag   = r4_tag;

  // Sigmoid reuses the tanh table on x/2.
  assign w_xp = r0_mode ? (r0_x >>> 1) : r0_x;
  assign w_xe = (BW+1)'(w_xp);

  always_comb begin
    w_p2 = '0;
    w_p1 = '0;
    w_p0 = '0;
    if (w_xe < -THREE) begin
      w_p0 = -ONE;
    end else if (w_xe < -ONE) begin
      w_p2 = coef(184);
      w_p1 = coef(953);
      w_p0 = coef(-815);
    end else if (w_xe[BW]) begin
      w_p2 = coef(647);
      w_p1 = coef(2220);
      w_p0 = coef(6);
    end else if (w_xe < ONE) begin
      w_p2 = coef(-649);
      w_p1 = coef(2223);
      w_p0 = coef(-7);
    end else if (w_xe < THREE) begin
      w_p2 = coef(-185);
      w_p1 = coef(953);
      w_p0 = coef(817);
    end else begin
      w_p0 = ONE;
    end
  end

  assign w_prod1 = PW'(r1_p2) * PW'(r1_x);
  assign w_m1    = (BW+1)'(w_prod1 >>> QM) + r1_p1;
  assign w_prod2 = PW'(r2_m1) * PW'(r2_x);
  assign w_m2    = (BW+1)'(w_prod2 >>> QM) + r2_p0;

  always_comb begin
    w_t = r3_m2;
    if (r3_m2 > ONE) begin
      w_t = ONE;
    end else if (r3_m2 < -ONE) begin
      w_t = -ONE;
    end
    w_sig = (ONE + w_t) >>> 1;
    w_res = r3_mode ? BW'(w_sig) : BW'(w_t);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r0_vld <= 1'b0;
      r1_vld <= 1'b0;
      r2_vld <= 1'b0;
      r3_vld <= 1'b0;
      r4_vld <= 1'b0;
      r4_dat <= '0;
      r4_tag <= '0;
    end else if (w_en) begin
      r0_vld <= in_valid;
      r1_vld <= r0_vld;
      r2_vld <= r1_vld;
      r3_vld <= r2_vld;
      r4_vld <= r3_vld;
      if (r3_vld) begin
        r4_dat <= w_res;
        r4_tag <= r3_tag;
      end
    end
  end

  // Datapath needs no reset: every stage is qualified by its valid bit.
  always_ff @(posedge clk) begin
    if (w_en) begin
      if (in_valid) begin
        r0_x    <= in_data;
        r0_mode <= in_mode;
        r0_tag  <= in_tag;
      end
      r1_x    <= w_xp;
      r1_p2   <= w_p2;
      r1_p1   <= w_p1;
      r1_p0   <= w_p0;
      r1_mode <= r0_mode;
      r1_tag  <= r0_tag;
      r2_x    <= r1_x;
      r2_m1   <= w_m1;
      r2_p0   <= r1_p0;
      r2_mode <= r1_mode;
      r2_tag  <= r1_tag;
      r3_m2   <= w_m2;
      r3_mode <= r2_mode;
      r3_tag  <= r2_tag;
    end
  end

endmodule

// File: tb/tb_pwq_activation.sv
// Directed and randomised checks of pwq_activation at QN=6, QM=11, TAG_W=4.
module tb_pwq_activation;
  localparam int QN    = 6;
  localparam int QM    = 11;
  localparam int TAG_W = 4;
  localparam int BW    = QN + QM + 1;

  logic             clk = 1'b0;
  logic             reset = 1'b0;
  logic             in_valid, in_ready, in_mode;
  logic             out_valid, out_ready;
  logic [BW-1:0]    in_data, out_data;
  logic [TAG_W-1:0] in_tag, out_tag;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  pwq_activation #(.QN(QN), .QM(QM), .TAG_W(TAG_W)) dut (
    .clk(clk), .reset(reset),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .in_mode(in_mode), .in_tag(in_tag),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_data(out_data), .out_tag(out_tag)
  );

  // Reference arithmetic in plain integers, QM = 11.
  function automatic int model(input int x, input bit mode);
    longint xp, p2, p1, p0, m1, m2, t;
    xp = mode ? longint'(x >>> 1) : longint'(x);
    if (xp < -6144)      begin p2 = 0;    p1 = 0;    p0 = -2048; end
    else if (xp < -2048) begin p2 = 184;  p1 = 953;  p0 = -815;  end
    else if (xp < 0)     begin p2 = 647;  p1 = 2220; p0 = 6;     end
    else if (xp < 2048)  begin p2 = -649; p1 = 2223; p0 = -7;    end
    else if (xp < 6144)  begin p2 = -185; p1 = 953;  p0 = 817;   end
    else                 begin p2 = 0;    p1 = 0;    p0 = 2048;  end
    m1 = ((p2 * xp) >>> 11) + p1;
    m2 = ((m1 * xp) >>> 11) + p0;
    t  = (m2 > 2048) ? 2048 : ((m2 < -2048) ? -2048 : m2);
    return mode ? int'((2048 + t) >>> 1) : int'(t);
  endfunction

  task automatic test_reset();
    in_valid = 1'b0; in_data = '0; in_mode = 1'b0; in_tag = '0; out_ready = 1'b1;
    #2 reset = 1'b1;
    #10;
    n_cmp++;
    if (out_valid !== 1'b0 || out_data !== '0 || out_tag !== '0) begin
      n_err++;
      $display("FAIL reset_state: valid=%b data=%0d tag=%0d, want 0/0/0", out_valid, out_data, out_tag);
    end
    @(negedge clk) reset = 1'b0;
    @(posedge clk); #1;
    n_cmp++;
    if (in_ready !== 1'b1) begin
      n_err++;
      $display("FAIL reset_in_ready: got %b want 1", in_ready);
    end
  endtask

  task automatic test_points();
    int xs[8] = '{0, 2048, 8192, -8192, 0, 2048, 16384, -16384};
    bit md[8] = '{0, 0, 0, 0, 1, 1, 1, 1};
    int ex[8] = '{-7, 1585, 2048, -2048, 1020, 1495, 2048, 0};
    out_ready = 1'b1;
    @(posedge clk); #1;
    for (int k = 0; k < 12; k++) begin
      if (k < 8) begin
        in_valid = 1'b1; in_data = BW'(xs[k]); in_mode = md[k]; in_tag = TAG_W'(k);
      end else begin
        in_valid = 1'b0;
      end
      @(posedge clk); #1;
      if (k >= 4) begin
        n_cmp++;
        if (out_valid !== 1'b1 || out_data !== BW'(ex[k-4]) || out_tag !== TAG_W'(k-4)) begin
          n_err++;
          $display("FAIL point[%0d]: valid=%b data=%0d tag=%0d, want 1/%0d/%0d",
                   k-4, out_valid, $signed(out_data), out_tag, ex[k-4], k-4);
        end
      end else if (k == 3) begin
        n_cmp++;
        if (out_valid !== 1'b0) begin
          n_err++;
          $display("FAIL latency_early: out_valid=%b after 3 edges, want 0", out_valid);
        end
      end
    end
  endtask

  task automatic test_boundaries();
    int xs[13] = '{-131072, -6145, -6144, -2049, -2048, -1, 0, 2047, 6143, 6144, 131071, -131072, 131071};
    bit md[13] = '{0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 1};
    int ex[13] = '{-2048, -2048, -2018, -1584, -1567, 4, -7, 1566, 2010, 2048, 2048, 0, 2048};
    out_ready = 1'b1;
    @(posedge clk); #1;
    for (int k = 0; k < 17; k++) begin
      if (k < 13) begin
        in_valid = 1'b1; in_data = BW'(xs[k]); in_mode = md[k]; in_tag = TAG_W'(k);
      end else begin
        in_valid = 1'b0;
      end
      @(posedge clk); #1;
      if (k >= 4) begin
        n_cmp++;
        if (out_valid !== 1'b1 || out_data !== BW'(ex[k-4]) || out_tag !== TAG_W'(k-4)) begin
          n_err++;
          $display("FAIL boundary x=%0d: valid=%b data=%0d, want 1/%0d",
                   xs[k-4], out_valid, $signed(out_data), ex[k-4]);
        end
      end
    end
  endtask

  task automatic test_back_to_back();
    int xs[64];
    int ex[64];
    int rcv = 0;
    logic [BW-1:0] r;
    for (int k = 0; k < 64; k++) begin
      if (k % 4 == 3) begin
        r = BW'($urandom);
        xs[k] = int'($signed(r));
      end else begin
        xs[k] = int'($urandom_range(0, 16383)) - 8192;
      end
      ex[k] = model(xs[k], (k % 2) == 1);
    end
    out_ready = 1'b1;
    @(posedge clk); #1;
    for (int k = 0; k < 68; k++) begin
      if (k < 64) begin
        in_valid = 1'b1; in_data = BW'(xs[k]); in_mode = (k % 2) == 1; in_tag = TAG_W'(k);
      end else begin
        in_valid = 1'b0;
      end
      @(posedge clk); #1;
      if (k >= 4) begin
        n_cmp++;
        if (out_valid !== 1'b1 || out_data !== BW'(ex[k-4]) || out_tag !== TAG_W'(k-4)) begin
          n_err++;
          $display("FAIL stream[%0d] x=%0d: valid=%b data=%0d tag=%0d, want 1/%0d/%0d",
                   k-4, xs[k-4], out_valid, $signed(out_data), out_tag, ex[k-4], (k-4) % 16);
        end
        if (out_valid === 1'b1) rcv++;
      end
    end
    n_cmp++;
    if (rcv != 64) begin
      n_err++;
      $display("FAIL stream_count: got %0d results in 67 cycles, want 64", rcv);
    end
  endtask

  task automatic test_backpressure();
    int q_dat[$];
    int q_tag[$];
    int n_in = 0;
    int n_out = 0;
    int tg = 0;
    int e_dat, e_tag;
    bit stall = 1'b0;
    logic [BW-1:0] hd, r;
    logic [TAG_W-1:0] ht;
    @(posedge clk); #1;
    for (int c = 0; c < 400; c++) begin
      if (c < 300) begin
        r = BW'($urandom);
        in_valid  = ($urandom_range(0, 2) != 0);
        in_data   = r;
        in_mode   = $urandom_range(0, 1) == 1;
        in_tag    = TAG_W'(tg);
        out_ready = $urandom_range(0, 1) == 1;
      end else begin
        in_valid  = 1'b0;
        out_ready = 1'b1;
      end
      @(negedge clk);
      n_cmp++;
      if (in_ready !== !(out_valid && !out_ready)) begin
        n_err++;
        $display("FAIL bp_in_ready: in_ready=%b out_valid=%b out_ready=%b", in_ready, out_valid, out_ready);
      end
      if (stall) begin
        n_cmp++;
        if (out_valid !== 1'b1 || out_data !== hd || out_tag !== ht) begin
          n_err++;
          $display("FAIL bp_hold: valid=%b data=%0d tag=%0d, want 1/%0d/%0d",
                   out_valid, $signed(out_data), out_tag, $signed(hd), ht);
        end
      end
      if (in_valid && in_ready) begin
        q_dat.push_back(model(int'($signed(in_data)), in_mode));
        q_tag.push_back(tg % 16);
        tg++;
        n_in++;
      end
      if (out_valid && out_ready) begin
        n_cmp++;
        n_out++;
        if (q_dat.size() == 0) begin
          n_err++;
          $display("FAIL bp_extra: unexpected result data=%0d tag=%0d, want none", $signed(out_data), out_tag);
        end else begin
          e_dat = q_dat.pop_front();
          e_tag = q_tag.pop_front();
          if (out_data !== BW'(e_dat) || out_tag !== TAG_W'(e_tag)) begin
            n_err++;
            $display("FAIL bp_data: data=%0d tag=%0d, want %0d/%0d", $signed(out_data), out_tag, e_dat, e_tag);
          end
        end
      end
      stall = out_valid && !out_ready;
      hd = out_data;
      ht = out_tag;
      @(posedge clk); #1;
    end
    n_cmp++;
    if (q_dat.size() != 0 || n_in != n_out || n_in < 100) begin
      n_err++;
      $display("FAIL bp_count: accepted=%0d emitted=%0d left=%0d, want equal and none left",
               n_in, n_out, q_dat.size());
    end
  endtask

  task automatic test_reset_midstream();
    int xs[4] = '{2048, -2048, 0, 6143};
    out_ready = 1'b1;
    @(posedge clk); #1;
    for (int k = 0; k < 4; k++) begin
      in_valid = 1'b1; in_data = BW'(xs[k]); in_mode = 1'b0; in_tag = TAG_W'(k + 1);
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
    @(posedge clk); #1;
    n_cmp++;
    if (out_valid !== 1'b1 || out_data !== BW'(1585) || out_tag !== TAG_W'(1)) begin
      n_err++;
      $display("FAIL mid_pre: valid=%b data=%0d tag=%0d, want 1/1585/1", out_valid, $signed(out_data), out_tag);
    end
    #3 reset = 1'b1;
    #1;
    n_cmp++;
    if (out_valid !== 1'b0 || out_data !== '0 || out_tag !== '0) begin
      n_err++;
      $display("FAIL mid_async_clear: valid=%b data=%0d tag=%0d, want 0/0/0", out_valid, out_data, out_tag);
    end
    @(posedge clk); #1;
    @(negedge clk) reset = 1'b0;
    for (int k = 0; k < 8; k++) begin
      @(posedge clk); #1;
      n_cmp++;
      if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
        n_err++;
        $display("FAIL mid_stale[%0d]: out_valid=%b in_ready=%b, want 0/1", k, out_valid, in_ready);
      end
    end
    in_valid = 1'b1; in_data = BW'(-2048); in_mode = 1'b0; in_tag = TAG_W'(7);
    for (int k = 0; k < 5; k++) begin
      @(posedge clk); #1;
      in_valid = 1'b0;
      n_cmp++;
      if (k == 4) begin
        if (out_valid !== 1'b1 || out_data !== BW'(-1567) || out_tag !== TAG_W'(7)) begin
          n_err++;
          $display("FAIL mid_after: valid=%b data=%0d tag=%0d, want 1/-1567/7", out_valid, $signed(out_data), out_tag);
        end
      end else if (out_valid !== 1'b0) begin
        n_err++;
        $display("FAIL mid_early[%0d]: out_valid=%b, want 0", k, out_valid);
      end
    end
  endtask

  initial begin
    test_reset();
    test_points();
    test_boundaries();
    test_back_to_back();
    test_backpressure();
    test_reset_midstream();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation exceeded 200000 time units, want completion");
    $fatal(1, "timeout");
  end

endmodule
